mem: RTL

Memory-access stage of the five-stage pipeline, between the EX/MEM pipeline register and the MEM/WB register. Non-memory instructions pass through unchanged in zero cycles. Loads and stores run a request/acknowledge transaction on the data-memory bus and stall the pipeline until it completes. Load data is lane-selected and extended before it goes to write-back.

---
 rtl/mem_if.sv | 22 ++
 rtl/mem.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_if.sv
// Data-memory bus between the memory-access stage (master) and the data
// memory (slave). The master issues registered requests, and the slave
// answers each request with a one-cycle d_ack pulse.
interface mem_if;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [3:0]  d_sel;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;

   modport master (
      output d_req, d_we, d_addr, d_sel, d_wdata,
      input  d_rdata, d_ack
   );

   modport slave (
      input  d_req, d_we, d_addr, d_sel, d_wdata,
      output d_rdata, d_ack
   );
endinterface

// File: rtl/mem.sv
// Memory-access stage: sits between EX/MEM and MEM/WB.
// Non-memory ops pass straight through with no added cycles. Loads and stores
// run one request/ack transaction on the data bus and stall the pipeline
// until the transaction finishes (IDLE -> BUSY -> DONE). Load data is
// lane-selected and sign- or zero-extended before it is written back.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word
// accesses (excp_misalign) instead of silently aligning them.
module mem (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  mem_op_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_sdata_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        stall_req,
   output logic        excp_misalign,
   mem_if.master       bus
);

   localparam logic RSTENABLE = 1'b1;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        d_req_q, d_req_d;
   logic        d_we_q, d_we_d;
   logic [31:0] d_addr_q, d_addr_d;
   logic [3:0]  d_sel_q, d_sel_d;
   logic [31:0] d_wdata_q, d_wdata_d;
   logic [31:0] load_q, load_d;

   logic        is_load, is_store, is_mem;
   logic        is_byte, is_half, is_word;
   logic        misalign;
   logic [1:0]  lane;
   logic [3:0]  sel;
   logic [31:0] store_data;
   logic [31:0] load_ext;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [7:0]  rd_bytes [4];

   assign lane = mem_addr_i[1:0];

   // Split the read word into its four byte lanes (lane i = addr[1:0] == i).
   for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_bytes[gi] = bus.d_rdata[8*gi +: 8];
   end

   // Decode the operation class and access size.
   always_comb begin
      is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
      is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
      is_mem   = is_load || is_store;
      is_byte  = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
      is_half  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
      is_word  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
   end

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = (is_half && lane[0]) || (is_word && (lane != 2'b00));
`else
   // Without the check, half/word ops simply ignore the low address bits.
   assign misalign = 1'b0;
`endif

   // Byte-lane enables and replicated store data for the current op.
   always_comb begin
      sel        = 4'b1111;
      store_data = mem_sdata_i;
      if (is_byte) begin
         sel        = 4'b0001 << lane;
         store_data = {4{mem_sdata_i[7:0]}};
      end else if (is_half) begin
         sel        = lane[1] ? 4'b1100 : 4'b0011;
         store_data = {2{mem_sdata_i[15:0]}};
      end
      if (!is_store) begin
         store_data = 32'h0;
      end
   end

   // Select the addressed lane of the read data and extend it to 32 bits.
   always_comb begin
      lane_byte = rd_bytes[lane];
      lane_half = lane[1] ? bus.d_rdata[31:16] : bus.d_rdata[15:0];
      load_ext  = bus.d_rdata;
      case (mem_op_i)
         OP_LB:   load_ext = {{24{lane_byte[7]}}, lane_byte};
         OP_LBU:  load_ext = {24'h0, lane_byte};
         OP_LH:   load_ext = {{16{lane_half[15]}}, lane_half};
         OP_LHU:  load_ext = {16'h0, lane_half};
         default: load_ext = bus.d_rdata;
      endcase
   end

   // State, bus and load-latch registers.
   always_ff @(posedge clk) begin
      if (rst == RSTENABLE) begin
         state_q   <= IDLE;
         d_req_q   <= 1'b0;
         d_we_q    <= 1'b0;
         d_addr_q  <= 32'h0;
         d_sel_q   <= 4'h0;
         d_wdata_q <= 32'h0;
         load_q    <= 32'h0;
      end else begin
         state_q   <= state_d;
         d_req_q   <= d_req_d;
         d_we_q    <= d_we_d;
         d_addr_q  <= d_addr_d;
         d_sel_q   <= d_sel_d;
         d_wdata_q <= d_wdata_d;
         load_q    <= load_d;
      end
   end

   // Next-state, bus updates and pipeline-facing outputs.
   always_comb begin
      state_d       = state_q;
      d_req_d       = d_req_q;
      d_we_d        = d_we_q;
      d_addr_d      = d_addr_q;
      d_sel_d       = d_sel_q;
      d_wdata_d     = d_wdata_q;
      load_d        = load_q;
      wd_o          = wd_i;
      wreg_o        = wreg_i;
      wdata_o       = wdata_i;
      stall_req     = 1'b0;
      excp_misalign = 1'b0;

      case (state_q)
         IDLE: begin
            if (is_mem) begin
               wreg_o = 1'b0;
               if (misalign) begin
                  // Trapped access: no bus request, no stall, stay in IDLE.
                  excp_misalign = 1'b1;
               end else begin
                  stall_req = 1'b1;
                  d_req_d   = 1'b1;
                  d_we_d    = is_store;
                  d_addr_d  = {mem_addr_i[31:2], 2'b00};
                  d_sel_d   = sel;
                  d_wdata_d = store_data;
                  state_d   = BUSY;
               end
            end
         end
         BUSY: begin
            stall_req = 1'b1;
            wreg_o    = 1'b0;
            if (bus.d_ack) begin
               d_req_d = 1'b0;
               d_we_d  = 1'b0;
               d_sel_d = 4'h0;
               if (is_load) begin
                  load_d = load_ext;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            // One write-back cycle, then back to IDLE so the op is not reissued.
            if (is_load) begin
               wdata_o = load_q;
            end else begin
               wreg_o = 1'b0;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rst == RSTENABLE) begin
         wd_o          = 5'h0;
         wreg_o        = 1'b0;
         wdata_o       = 32'h0;
         stall_req     = 1'b0;
         excp_misalign = 1'b0;
      end
   end

   assign bus.d_req   = d_req_q;
   assign bus.d_we    = d_we_q;
   assign bus.d_addr  = d_addr_q;
   assign bus.d_sel   = d_sel_q;
   assign bus.d_wdata = d_wdata_q;

endmodule
